dmem_bridge: RTL and testbench

//  Data-side memory bridge downstream of the MIPS data path: takes the ALU address, store data and
//  the controller's mem_read/mem_write, and runs a req/ack transaction on a variable-latency memory bus.

---
 rtl/dmem_bridge.sv | 114 +++++++++++
 tb/tb_dmem_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// Data-side memory bridge: turns level load/store requests into a req/ack
// bus transaction, stalling the pipeline until the access completes.
module dmem_bridge #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic access, both, misal, legal, tmo;

  assign access = mem_read | mem_write;
  assign both   = mem_read & mem_write;
  assign misal  = access && (addr[1:0] != 2'b00);
  assign legal  = access & ~both & ~misal;
  assign tmo    = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (legal) begin
          stall     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_ack || tmo) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdata     <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_req   <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      cnt       <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (both) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end else if (misal) begin
            err      <= 1'b1;
            err_code <= 2'b01;
          end else if (legal) begin
            bus_addr  <= {addr[DATA_W-1:2], 2'b00};
            bus_wdata <= wdata;
            bus_we    <= mem_write;
            bus_req   <= 1'b1;
            cnt       <= '0;
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= bus_rdata;
          end else if (tmo) begin
            // abort: load result forced to zero so no stale data commits
            bus_req  <= 1'b0;
            rdata    <= '0;
            err      <= 1'b1;
            err_code <= 2'b11;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: loads, stores, error cases,
// bus timeout and asynchronous reset during a transaction.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        stall, err;
  logic [1:0]  err_code;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  dmem_bridge #(.DATA_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .arst_n(arst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .err(err), .err_code(err_code),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stall)   stall_cnt++;
    if (bus_req) req_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    #12;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_code", {30'b0, err_code}, 32'h0);
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_baddr", bus_addr, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    step();

    // 1: load with ack in the third WAIT cycle
    stall_cnt = 0;
    mem_read = 1'b1; addr = 32'h40;
    #1 chk("t1_stall_idle", {31'b0, stall}, 32'h1);
    step();
    chk("t1_req", {31'b0, bus_req}, 32'h1);
    chk("t1_baddr", bus_addr, 32'h40);
    chk("t1_we", {31'b0, bus_we}, 32'h0);
    step();
    step();
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("t1_done_stall", {31'b0, stall}, 32'h0);
    chk("t1_rdata", rdata, 32'h1234_5678);
    chk("t1_req_low", {31'b0, bus_req}, 32'h0);
    mem_read = 1'b0;
    step();
    chk("t1_stall_cycles", stall_cnt, 4);
    chk("t1_idle_stall", {31'b0, stall}, 32'h0);

    // 2: store with ack in the first WAIT cycle
    stall_cnt = 0;
    mem_write = 1'b1; addr = 32'h80; wdata = 32'hCAFE_F00D;
    step();
    chk("t2_we", {31'b0, bus_we}, 32'h1);
    chk("t2_wdata", bus_wdata, 32'hCAFE_F00D);
    chk("t2_baddr", bus_addr, 32'h80);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_ack = 1'b0;
    mem_write = 1'b0;
    chk("t2_done_stall", {31'b0, stall}, 32'h0);
    chk("t2_rdata_kept", rdata, 32'h1234_5678);
    step();
    chk("t2_stall_cycles", stall_cnt, 2);

    // 3: misaligned load
    req_cnt = 0;
    mem_read = 1'b1; addr = 32'h42;
    #1 chk("t3_stall", {31'b0, stall}, 32'h0);
    step();
    mem_read = 1'b0;
    chk("t3_err", {31'b0, err}, 32'h1);
    chk("t3_code", {30'b0, err_code}, 32'h1);
    step();
    chk("t3_err_pulse", {31'b0, err}, 32'h0);
    chk("t3_code_hold", {30'b0, err_code}, 32'h1);

    // 4: read and write together
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h0;
    #1 chk("t4_stall", {31'b0, stall}, 32'h0);
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    chk("t4_err", {31'b0, err}, 32'h1);
    chk("t4_code", {30'b0, err_code}, 32'h2);
    step();
    chk("t4_err_pulse", {31'b0, err}, 32'h0);
    chk("t34_no_req", req_cnt, 0);

    // 5: load that never gets an ack
    req_cnt = 0; stall_cnt = 0;
    mem_read = 1'b1; addr = 32'h100;
    repeat (16) begin
      step();
      chk("t5_req_wait", {31'b0, bus_req}, 32'h1);
    end
    step();
    chk("t5_req_low", {31'b0, bus_req}, 32'h0);
    chk("t5_err", {31'b0, err}, 32'h1);
    chk("t5_code", {30'b0, err_code}, 32'h3);
    chk("t5_rdata", rdata, 32'h0);
    chk("t5_done_stall", {31'b0, stall}, 32'h0);
    mem_read = 1'b0;
    step();
    chk("t5_req_cycles", req_cnt, 16);
    chk("t5_stall_cycles", stall_cnt, 17);
    chk("t5_err_pulse", {31'b0, err}, 32'h0);
    chk("t5_code_hold", {30'b0, err_code}, 32'h3);

    // 6: async reset in WAIT, late ack must be ignored
    mem_read = 1'b1; addr = 32'h200;
    step();
    chk("t6_req", {31'b0, bus_req}, 32'h1);
    #2;
    arst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("t6_req_async", {31'b0, bus_req}, 32'h0);
    chk("t6_stall_async", {31'b0, stall}, 32'h0);
    chk("t6_err_async", {31'b0, err}, 32'h0);
    chk("t6_code_clr", {30'b0, err_code}, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    step();
    bus_ack = 1'b0;
    chk("t6_late_ack_req", {31'b0, bus_req}, 32'h0);
    chk("t6_late_ack_rdata", rdata, 32'h0);
    chk("t6_late_ack_stall", {31'b0, stall}, 32'h0);
    step();
    chk("t6_late_ack_err", {31'b0, err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
